// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory SRAM responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_mem_pkg;

    // Access sequencer states: request, low half-word, high half-word, completion
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int          SRAM_DW       = 16;
    localparam int          CNT_W         = 4;
    localparam int unsigned DEF_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_responder_wait_counter.sv
// Wait-state counter: load a phase length, count down, flag the final cycle.
// Latency: 'last' is registered-count decode, asserted while count==1.
// Backpressure: none; load has priority over decrement.
module wait_counter
    import arm_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload at the start of each phase, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/sram_responder.sv
// Serves 32-bit MEM-stage loads/stores as two 16-bit async-SRAM phases; optional BUS_ERR_EN adds 'err'.
// Latency: request in cycle 0, ready in cycle 2*WAIT_CYCLES+1 (cycle 1 for a rejected misaligned access).
// Backpressure: ready low stalls the pipeline; request inputs sampled only in IDLE.
module sram_responder
    import arm_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
`ifdef BUS_ERR_EN
    ,
    output logic               err
`endif
);

    state_e             state_q, state_d;
    logic [SRAM_AW-2:0] waddr_q, waddr_d, waddr_in;
    logic [31:0]        wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0] dq_o_q, dq_o_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               req, accept, go_err, last, cnt_load;

    assign req      = mem_r_en | mem_w_en;
    assign accept   = (state_q == ST_IDLE) & req;
    // Word index relative to the data-memory base; upper bits wrap away on truncation
    assign waddr_in = (SRAM_AW-1)'((addr - 32'(BASE_ADDR)) >> 2);

`ifdef BUS_ERR_EN
    logic err_q, err_d;
    assign go_err = addr[1:0] != 2'b00;
    assign err_d  = accept & go_err;
    assign err    = err_q;

    // Error flag is high only during the DONE cycle of a rejected access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign go_err = 1'b0;
`endif

    // Phase length counter is restarted on entry to LO and to HI
    assign cnt_load = (accept & ~go_err) | ((state_q == ST_LO) & last);

    wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .last     (last)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: each half-word phase ends on the counter's last cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req)  state_d = go_err ? ST_DONE : ST_LO;
            ST_LO:   if (last) state_d = ST_HI;
            ST_HI:   if (last) state_d = ST_DONE;
            default:           state_d = ST_IDLE;
        endcase
    end

    // Outputs: ready, plus SRAM pin values decoded from the state being entered
    always_comb begin
        ready       = (state_q == ST_DONE) | ((state_q == ST_IDLE) & ~req);
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        if ((state_d == ST_LO) || (state_d == ST_HI)) begin
            ce_n_d      = 1'b0;
            sram_addr_d = {waddr_d, state_d == ST_HI};
            if (is_wr_d) begin
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                dq_o_d  = (state_d == ST_HI) ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                oe_n_d  = 1'b0;
            end
        end
    end

    // Request capture in IDLE and read-data capture on each read phase's last cycle
    always_comb begin
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        if (accept) begin
            waddr_d = waddr_in;
            wdata_d = wdata;
            is_wr_d = mem_w_en;
        end
        if (!is_wr_q && last) begin
            if (state_q == ST_LO) rdata_d[15:0]  = sram_dq_i;
            if (state_q == ST_HI) rdata_d[31:16] = sram_dq_i;
        end
    end

    // Datapath and SRAM pin registers; reset forces the pins idle immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr_q     <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign rdata      = rdata_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized self-checking bench for sram_responder against a word-level memory model.
// Latency: expects ready 2*W+1 cycles after a request is presented.
// Backpressure: requests held until ready, then dropped; next request in the following cycle.
module tb_sram_responder;

    localparam int W   = 2;
    localparam int LAT = 2 * W + 1;
    localparam int AW  = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0]   addr = '0, wdata = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef BUS_ERR_EN
    logic          err;
`endif

    int n_vec = 0;
    int n_err = 0;

    // External SRAM model and word-level reference memory
    logic [15:0] sram    [0:1023] = '{default: 16'h0000};
    logic [31:0] ref_mem [0:63]   = '{default: 32'h0};
    logic [31:0] exp_rdata = '0;

    // Per-cycle pin trace of the last transaction
    logic [AW-1:0] tr_addr [0:39];
    logic [15:0]   tr_dq   [0:39];
    logic          tr_we [0:39], tr_oe [0:39], tr_ce [0:39], tr_dqoe [0:39];
    logic [31:0]   got_rdata;
    logic          got_err;

    always #5 clk = ~clk;

    sram_responder #(.BASE_ADDR(1024), .SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
`ifdef BUS_ERR_EN
        ,
        .err        (err)
`endif
    );

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[9:0]] : 16'hxxxx;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram[sram_addr[9:0]] <= sram_dq_o;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present a request, hold it until ready, record the pin trace; lat=-1 on timeout
    task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        @(negedge clk);
        mem_w_en = w; mem_r_en = r; addr = a; wdata = d;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            tr_addr[c] = sram_addr; tr_dq[c] = sram_dq_o; tr_we[c] = sram_we_n;
            tr_oe[c] = sram_oe_n; tr_ce[c] = sram_ce_n; tr_dqoe[c] = sram_dq_oe;
            if (ready) begin
                lat = c;
                got_rdata = rdata;
`ifdef BUS_ERR_EN
                got_err = err;
`else
                got_err = 1'b0;
`endif
                break;
            end
        end
        mem_w_en = 1'b0; mem_r_en = 1'b0;
    endtask

    // Pin timeline expected for a full two-phase access of word index k
    task automatic check_pins(input string tag, input logic w, input int k, input logic [31:0] d);
        logic ok;
        logic [AW-1:0] ea;
        ok = (tr_ce[0] === 1'b1) && (tr_ce[LAT] === 1'b1);
        for (int c = 1; c <= 2 * W; c++) begin
            ea = AW'(2 * k + ((c > W) ? 1 : 0));
            if (tr_ce[c] !== 1'b0 || tr_addr[c] !== ea || tr_we[c] !== !w ||
                tr_oe[c] !== w || tr_dqoe[c] !== w) ok = 1'b0;
            if (w && tr_dq[c] !== ((c > W) ? d[31:16] : d[15:0])) ok = 1'b0;
        end
        chk(tag, ok, 1'b1);
    endtask

    initial begin
        int lat, k;
        logic w, r;
        logic [31:0] a, d;

        // 1: reset state
        repeat (3) @(negedge clk);
        chk("rst_ce_n", sram_ce_n, 1'b1);
        chk("rst_dq_oe", sram_dq_oe, 1'b0);
        rst = 1'b1;
        #1;
        chk("idle_ready", ready, 1'b1);
        chk("idle_we_n", sram_we_n, 1'b1);
        chk("idle_oe_n", sram_oe_n, 1'b1);
        chk("idle_rdata", rdata, 32'h0);

        // 2: write DEAD_BEEF to word 1
        do_req(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, lat);
        ref_mem[1] = 32'hDEAD_BEEF;
        chk("wr_lat", lat, LAT);
        chk("wr_lo_addr", tr_addr[1], 2);
        chk("wr_lo_dq", tr_dq[2], 16'hBEEF);
        chk("wr_lo_we", tr_we[1], 1'b0);
        chk("wr_hi_addr", tr_addr[4], 3);
        chk("wr_hi_dq", tr_dq[3], 16'hDEAD);
        check_pins("wr_pins", 1'b1, 1, 32'hDEAD_BEEF);
        chk("wr_rdata_kept", got_rdata, 32'h0);

        // 3: read it back
        do_req(1'b0, 1'b1, 32'd1028, 32'h0, lat);
        exp_rdata = 32'hDEAD_BEEF;
        chk("rd_lat", lat, LAT);
        chk("rd_data", got_rdata, exp_rdata);
        check_pins("rd_pins", 1'b0, 1, 32'h0);

        // 4: read+write together performs the write; then back-to-back reads
        do_req(1'b1, 1'b1, 32'd1024, 32'h1234_5678, lat);
        ref_mem[0] = 32'h1234_5678;
        chk("rw_lat", lat, LAT);
        chk("rw_rdata_kept", got_rdata, exp_rdata);
        check_pins("rw_pins", 1'b1, 0, 32'h1234_5678);
        do_req(1'b0, 1'b1, 32'd1024, 32'h0, lat);
        chk("b2b0_lat", lat, LAT);
        chk("b2b0_data", got_rdata, 32'h1234_5678);
        do_req(1'b0, 1'b1, 32'd1028, 32'h0, lat);
        chk("b2b1_lat", lat, LAT);
        chk("b2b1_data", got_rdata, 32'hDEAD_BEEF);
        exp_rdata = 32'hDEAD_BEEF;

        // Randomized traffic against the word-level model
        for (int t = 0; t < 60; t++) begin
            k = $urandom_range(0, 63);
            a = 32'd1024 + 32'(4 * k);
`ifndef BUS_ERR_EN
            a = a + 32'($urandom_range(0, 3));
`endif
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            do_req(w, r, a, d, lat);
            chk("rnd_lat", lat, LAT);
            if (w) ref_mem[k] = d;
            else   exp_rdata = ref_mem[k];
            chk("rnd_rdata", got_rdata, exp_rdata);
            check_pins("rnd_pins", w, k, d);
        end

`ifdef BUS_ERR_EN
        // 6: misaligned access is rejected without touching the SRAM
        do_req(1'b0, 1'b1, 32'd1030, 32'h0, lat);
        chk("err_lat", lat, 1);
        chk("err_flag", got_err, 1'b1);
        chk("err_ce_n", tr_ce[0] & tr_ce[1], 1'b1);
        chk("err_rdata", got_rdata, exp_rdata);
        @(negedge clk);
        chk("err_clear", err, 1'b0);
`endif

        // 5: reset during the second HI cycle of a write
        @(negedge clk);
        mem_w_en = 1'b1; addr = 32'd1024 + 32'd400; wdata = 32'hCAFE_F00D;
        repeat (4) @(negedge clk);
        #1;
        chk("hi2_we", sram_we_n, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_ce_n", sram_ce_n, 1'b1);
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_dq_oe", sram_dq_oe, 1'b0);
        mem_w_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", ready, 1'b1);
        do_req(1'b0, 1'b1, 32'd1024, 32'h0, lat);
        chk("post_rst_lat", lat, LAT);
        chk("post_rst_data", got_rdata, ref_mem[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
